// File: rtl/count_display_driver.sv
// Samples an asynchronous 4-bit counter into the board clock domain and filters it.
// Scans the result as decimal 00-15 on a 2-digit common-anode 7-segment display.
module count_display_driver #(
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter int unsigned RCNT_W        = 16,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] count,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] value,
  output logic       change,
  output logic       wrap
);

  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REFRESH_DIV - 32'd1);

  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'h40;
      4'd1:    code = 7'h79;
      4'd2:    code = 7'h24;
      4'd3:    code = 7'h30;
      4'd4:    code = 7'h19;
      4'd5:    code = 7'h12;
      4'd6:    code = 7'h02;
      4'd7:    code = 7'h78;
      4'd8:    code = 7'h00;
      4'd9:    code = 7'h10;
      default: code = 7'h7F;
    endcase
    return code;
  endfunction

  logic [3:0]        s1_r, s2_r, s3_r;
  logic [RCNT_W-1:0] rcnt_r;
  logic              sel_r;
  logic              load_s;
  logic              tens_s;
  logic [3:0]        ones_s;
  logic [6:0]        seg_nxt_s;
  logic [1:0]        an_nxt_s;

  // Two samples of s2 must agree before a code is trusted.
  assign load_s = (s2_r == s3_r);

  // Synchroniser, agreement filter and change/wrap event flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_r   <= 4'd0;
      s2_r   <= 4'd0;
      s3_r   <= 4'd0;
      value  <= 4'd0;
      change <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      s1_r <= count;
      s2_r <= s1_r;
      s3_r <= s2_r;
      if (load_s) begin
        value  <= s2_r;
        change <= (s2_r != value);
        wrap   <= (value == 4'd15) && (s2_r == 4'd0);
      end else begin
        change <= 1'b0;
        wrap   <= 1'b0;
      end
    end
  end

  // Refresh divider; sel_r=0 lights the ones digit, 1 the tens digit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rcnt_r <= {RCNT_W{1'b0}};
      sel_r  <= 1'b0;
    end else if (rcnt_r == RCNT_LAST) begin
      rcnt_r <= {RCNT_W{1'b0}};
      sel_r  <= ~sel_r;
    end else begin
      rcnt_r <= rcnt_r + RCNT_W'(1'b1);
      sel_r  <= sel_r;
    end
  end

  // Binary to two-digit BCD for the 0..15 range
  always_comb begin
    tens_s = 1'b0;
    ones_s = value;
    if (value >= 4'd10) begin
      tens_s = 1'b1;
      ones_s = value - 4'd10;
    end else begin
      tens_s = 1'b0;
      ones_s = value;
    end
  end

  // Digit selection with optional leading-zero blanking
  always_comb begin
    an_nxt_s  = 2'b11;
    seg_nxt_s = 7'h7F;
    if (!sel_r) begin
      an_nxt_s  = 2'b10;
      seg_nxt_s = seg_code(ones_s);
    end else if (BLANK_LEADING && !tens_s) begin
      an_nxt_s  = 2'b11;
      seg_nxt_s = 7'h7F;
    end else begin
      an_nxt_s  = 2'b01;
      seg_nxt_s = seg_code({3'b000, tens_s});
    end
  end

  // Registered display drive
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg <= 7'h7F;
      an  <= 2'b11;
    end else begin
      seg <= seg_nxt_s;
      an  <= an_nxt_s;
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// Directed self-checking bench for count_display_driver; instance a blanks the
// leading zero, instance b shows it.
module tb_count_display_driver;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] count;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;
  logic [3:0] value_a, value_b;
  logic       change_a, change_b, wrap_a, wrap_b;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] model_value;
  logic [6:0] digit_codes [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                    7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  count_display_driver #(.REFRESH_DIV(DIV), .RCNT_W(4), .BLANK_LEADING(1'b1)) dut_a (
    .clk(clk), .rstn(rstn), .count(count), .seg(seg_a), .an(an_a),
    .value(value_a), .change(change_a), .wrap(wrap_a)
  );

  count_display_driver #(.REFRESH_DIV(DIV), .RCNT_W(4), .BLANK_LEADING(1'b0)) dut_b (
    .clk(clk), .rstn(rstn), .count(count), .seg(seg_b), .an(an_b),
    .value(value_b), .change(change_b), .wrap(wrap_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a new count and check the load point four edges later.
  task automatic step_count(input logic [3:0] nv, input logic exp_change, input logic exp_wrap);
    count = nv;
    tick(3);
    check("pre_value", value_a, model_value);
    check("pre_change", change_a, 1'b0);
    tick(1);
    check("load_value", value_a, nv);
    check("load_value_b", value_b, nv);
    check("load_change", change_a, exp_change);
    check("load_wrap", wrap_a, exp_wrap);
    tick(1);
    check("post_change", change_a, 1'b0);
    check("post_wrap", wrap_a, 1'b0);
    model_value = nv;
  endtask

  // Wait (bounded) for a digit slot and check its segment code.
  task automatic check_slot(input string tag, input bit dut_b_sel, input logic [1:0] an_want,
                            input logic [6:0] seg_exp);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 2 * DIV + 2; i++) begin
      if ((dut_b_sel ? an_b : an_a) == an_want) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
    check({tag, "_found"}, found, 1'b1);
    check(tag, dut_b_sel ? seg_b : seg_a, seg_exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         len;
    int         pulses;
    logic [3:0] nv;

    rstn        = 1'b0;
    count       = 4'd0;
    model_value = 4'd0;

    // Reset state
    tick(1);
    check("rst_seg", seg_a, 7'h7F);
    check("rst_an", an_a, 2'b11);
    check("rst_value", value_a, 4'd0);
    check("rst_change", change_a, 1'b0);
    check("rst_wrap", wrap_a, 1'b0);
    check("rst_seg_b", seg_b, 7'h7F);
    check("rst_an_b", an_b, 2'b11);
    rstn = 1'b1;
    tick(1);
    check("rel_an", an_a, 2'b10);
    check("rel_seg", seg_a, 7'h40);
    check("rel_an_b", an_b, 2'b10);

    // Latency 0 -> 5
    step_count(4'd5, 1'b1, 1'b0);
    check_slot("lat_ones", 1'b0, 2'b10, 7'h12);

    // Sweep 0..15
    for (int i = 0; i < 16; i++) begin
      nv = 4'(i);
      step_count(nv, (nv != model_value), 1'b0);
      check_slot("sweep_ones", 1'b0, 2'b10, digit_codes[i % 10]);
      if (i >= 10) begin
        check_slot("sweep_tens", 1'b0, 2'b01, 7'h79);
        check_slot("sweep_tens_b", 1'b1, 2'b01, 7'h79);
      end else begin
        check_slot("sweep_tens_blank", 1'b0, 2'b11, 7'h7F);
        check_slot("sweep_tens_b", 1'b1, 2'b01, 7'h40);
      end
      if (i == 12) begin
        check_slot("v12_ones", 1'b0, 2'b10, 7'h24);
        for (int k = 0; k < 12 && an_a == 2'b10; k++) tick(1);
        for (int k = 0; k < 12 && an_a != 2'b10; k++) tick(1);
        len = 0;
        while (an_a == 2'b10 && len < 20) begin
          len++;
          tick(1);
        end
        check("slot_len", len, DIV);
      end
      tick(4);
    end

    // Wrap and non-wrap transitions
    step_count(4'd0, 1'b1, 1'b1);
    step_count(4'd14, 1'b1, 1'b0);
    step_count(4'd15, 1'b1, 1'b0);
    step_count(4'd15, 1'b0, 1'b0);
    step_count(4'd1, 1'b1, 1'b0);
    step_count(4'd14, 1'b1, 1'b0);
    step_count(4'd0, 1'b1, 1'b0);

    // One-sample glitch must never load
    step_count(4'd7, 1'b1, 1'b0);
    count = 4'd6;
    tick(1);
    count  = 4'd8;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check("glitch_not6", (value_a == 4'd7) || (value_a == 4'd8), 1'b1);
      if (change_a) pulses++;
    end
    check("glitch_value", value_a, 4'd8);
    check("glitch_pulses", pulses, 1);
    model_value = 4'd8;

    // Leading-zero blanking on/off
    step_count(4'd3, 1'b1, 1'b0);
    check_slot("blank_tens_a", 1'b0, 2'b11, 7'h7F);
    check_slot("blank_tens_b", 1'b1, 2'b01, 7'h40);
    check_slot("blank_ones_b", 1'b1, 2'b10, 7'h30);

    // Asynchronous reset mid-scan
    tick(1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_seg", seg_a, 7'h7F);
    check("mid_rst_an", an_a, 2'b11);
    check("mid_rst_value", value_a, 4'd0);
    check("mid_rst_change", change_a, 1'b0);
    check("mid_rst_wrap", wrap_a, 1'b0);
    tick(1);
    check("mid_rst_hold_an", an_a, 2'b11);
    rstn = 1'b1;
    tick(1);
    check("mid_rel_an", an_a, 2'b10);
    check("mid_rel_seg", seg_a, 7'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
